clk_period_meter: RTL
=====================

// Module: clk_period_meter
// PURPOSE
//   Receive-side counterpart to the team's clock dividers. Measures a slow
//   clock or pulse train (I_SIG) in I_CLK cycles and reports its period and
//   high time once per input period.
//   Used to check divider outputs in hardware and to measure external slow
//   signals. Results feed the display/debug logic.
// PARAMETERS
//   W  16  width of period/high-time counters and outputs; saturation limit 2^W-1
// PORTS
//   I_CLK     in   1  system clock, rising edge active
//   rst_n     in   1  reset, asynchronous, active-low
//   EN        in   1  measurement enable, synchronous
//   I_SIG     in   1  signal under measurement; asynchronous to I_CLK
//   O_PERIOD  out  W  last complete rise-to-rise period, in I_CLK cycles
//   O_HIGH    out  W  high time of that same period, in I_CLK cycles
//   O_VALID   out  1  one-cycle pulse when O_PERIOD/O_HIGH update
//   O_STUCK   out  1  no rising edge seen within 2^W-1 cycles
// BEHAVIOUR
//   Reset (rst_n=0, async): all outputs 0, counters 0, sync flops 0, state IDLE.
//   Input path:
//     - I_SIG passes through a 2-flop synchronizer (s1->s2) plus a history flop s3.
//     - rise = s2 & ~s3; fall = ~s2 & s3.
//     - Detection latency: 3 I_CLK edges from the I_SIG transition.
//   States:
//     IDLE    : entered whenever EN=0 (overrides all states); cnt=hcnt=0; O_STUCK=0;
//               O_PERIOD/O_HIGH hold. EN=1 -> ARM.
//     ARM     : wait for first rise (no output). rise -> MEASURE, cnt<=1, hcnt<=1.
//     MEASURE : cnt+=1 each cycle; hcnt+=1 while s2=1.
//               fall -> hlat<=hcnt.
//               rise -> O_PERIOD<=cnt, O_HIGH<=hlat, O_VALID=1 next cycle,
//                 cnt<=1, hcnt<=1.
//               cnt==2^W-1 and no rise -> STUCK.
//     STUCK   : O_STUCK=1, counters frozen, O_VALID never asserted.
//               rise -> MEASURE, cnt<=1, hcnt<=1, O_STUCK<=0; first period after
//               recovery is measured normally.
//   Arithmetic:
//     - Period = cycles between detected rises (min 2).
//     - High time = cycles s2 was 1 (min 1, always < period).
//     - Counters never wrap; the saturation value 2^W-1 forces STUCK.
//     - A period of exactly 2^W-1 is reported as STUCK, not valid.
//   Simultaneous/boundary:
//     - rise in the same cycle cnt hits 2^W-1: rise wins, valid result published.
//     - EN falling in the same cycle as a rise: IDLE wins, no O_VALID.
//     - O_VALID is registered: asserted the cycle after the capturing rise, for
//       exactly 1 cycle.
//     - Glitches narrower than one I_CLK period may be missed; no filtering.
//     - Async reset mid-measurement discards partial counts.
//       After release, the first rise only arms.
// TESTING
//   1. Reset release, EN=1, I_SIG toggles every 11 I_CLK cycles -> first O_VALID
//      after the 2nd rise; O_PERIOD=22, O_HIGH=11, one O_VALID per 22 cycles.
//   2. Duty cycle: high 3/low 7 cycles -> O_PERIOD=10, O_HIGH=3; then minimum
//      high 1/low 1 -> O_PERIOD=2, O_HIGH=1.
//   3. W=8, I_SIG held low after arming -> O_STUCK=1 at cnt=255, no O_VALID;
//      resume 20-cycle toggling -> O_STUCK=0 on next rise, then O_PERIOD=40.
//   4. EN dropped mid-period -> no O_VALID, O_PERIOD holds; EN=1 again -> first
//      rise arms only, 2nd rise reports the correct period.
//   5. Assert rst_n=0 asynchronously between clock edges mid-measurement ->
//      outputs 0 immediately; after release behaviour matches test 1.
//   6. I_SIG edges at random sub-cycle phases vs I_CLK -> period stays within +/-1
//      of nominal; O_HIGH < O_PERIOD on every O_VALID.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures the rise-to-rise period and high time of a slow, asynchronous signal in I_CLK cycles.
// A result is published once per input period. If no rising edge arrives before the period counter saturates, the meter reports stuck.
module clk_period_meter #(
    parameter int W = 16
) (
    input  logic         I_CLK,
    input  logic         rst_n,
    input  logic         EN,
    input  logic         I_SIG,
    output logic [W-1:0] O_PERIOD,
    output logic [W-1:0] O_HIGH,
    output logic         O_VALID,
    output logic         O_STUCK
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_STUCK   = 2'd3
    } state_t;

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    // Last count at which a rise can still produce a valid result.
    localparam logic [W-1:0] CNT_LIM  = CNT_MAX - CNT_ONE;

    state_t         state_r;
    state_t         state_nxt_s;

    logic           s1_r;
    logic           s2_r;
    logic           s3_r;
    logic           rise_s;
    logic           fall_s;

    logic [W-1:0]   cnt_r;
    logic [W-1:0]   cnt_nxt_s;
    logic [W-1:0]   hcnt_r;
    logic [W-1:0]   hcnt_nxt_s;
    logic [W-1:0]   hlat_r;
    logic [W-1:0]   hlat_nxt_s;
    logic [W-1:0]   period_r;
    logic [W-1:0]   period_nxt_s;
    logic [W-1:0]   high_r;
    logic [W-1:0]   high_nxt_s;
    logic           valid_r;
    logic           valid_nxt_s;
    logic           stuck_r;
    logic           stuck_nxt_s;

    assign rise_s = s2_r & ~s3_r;
    assign fall_s = ~s2_r & s3_r;

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= I_SIG;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Next-state and datapath logic. EN low forces IDLE from any state.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        hcnt_nxt_s   = hcnt_r;
        hlat_nxt_s   = hlat_r;
        period_nxt_s = period_r;
        high_nxt_s   = high_r;
        valid_nxt_s  = 1'b0;
        stuck_nxt_s  = stuck_r;

        if (!EN) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            hcnt_nxt_s  = CNT_ZERO;
            stuck_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ARM;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_nxt_s = ST_MEASURE;
                        cnt_nxt_s   = CNT_ONE;
                        hcnt_nxt_s  = CNT_ONE;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_MEASURE: begin
                    if (rise_s) begin
                        period_nxt_s = cnt_r;
                        high_nxt_s   = hlat_r;
                        valid_nxt_s  = 1'b1;
                        cnt_nxt_s    = CNT_ONE;
                        hcnt_nxt_s   = CNT_ONE;
                    end else begin
                        if (fall_s) begin
                            hlat_nxt_s = hcnt_r;
                        end else begin
                            hlat_nxt_s = hlat_r;
                        end
                        if (s2_r) begin
                            hcnt_nxt_s = hcnt_r + CNT_ONE;
                        end else begin
                            hcnt_nxt_s = hcnt_r;
                        end
                        // Reaching saturation without a rise means no valid period is possible.
                        if (cnt_r == CNT_LIM) begin
                            cnt_nxt_s   = CNT_MAX;
                            state_nxt_s = ST_STUCK;
                            stuck_nxt_s = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_STUCK: begin
                    if (rise_s) begin
                        state_nxt_s = ST_MEASURE;
                        cnt_nxt_s   = CNT_ONE;
                        hcnt_nxt_s  = CNT_ONE;
                        stuck_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_STUCK;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    hcnt_nxt_s  = CNT_ZERO;
                    stuck_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            hcnt_r   <= CNT_ZERO;
            hlat_r   <= CNT_ZERO;
            period_r <= CNT_ZERO;
            high_r   <= CNT_ZERO;
            valid_r  <= 1'b0;
            stuck_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            hcnt_r   <= hcnt_nxt_s;
            hlat_r   <= hlat_nxt_s;
            period_r <= period_nxt_s;
            high_r   <= high_nxt_s;
            valid_r  <= valid_nxt_s;
            stuck_r  <= stuck_nxt_s;
        end
    end

    assign O_PERIOD = period_r;
    assign O_HIGH   = high_r;
    assign O_VALID  = valid_r;
    assign O_STUCK  = stuck_r;

endmodule
